// File: rtl/input_conditioner.sv
// Synchronizes and debounces an external input into a clean level and rising-edge pulse.
// Define INPUT_CONDITIONER_GLITCH_COUNT_EN to add the saturating out_glitches counter.
module input_conditioner #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       in_clock,
  input  logic       in_reset,
  input  logic       in_set,
  input  logic [7:0] in_value,
  output logic       out_ack,
  input  logic       in_raw,
  output logic       out_level,
`ifdef INPUT_CONDITIONER_GLITCH_COUNT_EN
  output logic       out_pulse,
  output logic [7:0] out_glitches
`else
  output logic       out_pulse
`endif
);

  typedef enum logic [1:0] {
    LOW,
    QUAL_HIGH,
    HIGH,
    QUAL_LOW
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [7:0]             thr_q;
  logic [7:0]             cnt_q;
  logic [7:0]             cnt_d;
  logic [8:0]             cnt_inc;
  logic                   reached;
  logic                   pulse_d;
  logic                   level_d;
  state_t                 state_q;
  state_t                 state_d;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset) begin
      sync_q  <= '0;
      thr_q   <= 8'd4;
      out_ack <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], in_raw};
      out_ack <= in_set;
      if (in_set)
        thr_q <= (in_value == 8'd0) ? 8'd1 : in_value;
    end
  end

  // 9-bit compare so a lowered threshold below cnt still qualifies
  assign cnt_inc = {1'b0, cnt_q} + 9'd1;
  assign reached = cnt_inc >= {1'b0, thr_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    unique case (state_q)
      LOW: begin
        if (s) begin
          if (thr_q == 8'd1) begin
            state_d = HIGH;
            pulse_d = 1'b1;
          end else begin
            state_d = QUAL_HIGH;
            cnt_d   = 8'd1;
          end
        end
      end
      QUAL_HIGH: begin
        if (!s) begin
          state_d = LOW;
        end else if (reached) begin
          state_d = HIGH;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_inc[7:0];
        end
      end
      HIGH: begin
        if (!s) begin
          if (thr_q == 8'd1) begin
            state_d = LOW;
          end else begin
            state_d = QUAL_LOW;
            cnt_d   = 8'd1;
          end
        end
      end
      QUAL_LOW: begin
        if (s) begin
          state_d = HIGH;
        end else if (reached) begin
          state_d = LOW;
        end else begin
          cnt_d = cnt_inc[7:0];
        end
      end
    endcase
  end

  assign level_d = (state_d == HIGH) || (state_d == QUAL_LOW);

  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset) begin
      state_q   <= LOW;
      cnt_q     <= 8'd0;
      out_level <= 1'b0;
      out_pulse <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      out_level <= level_d;
      out_pulse <= pulse_d;
    end
  end

`ifdef INPUT_CONDITIONER_GLITCH_COUNT_EN
  logic glitch;

  assign glitch = ((state_q == QUAL_HIGH) && !s) ||
                  ((state_q == QUAL_LOW) && s);

  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset)
      out_glitches <= 8'd0;
    else if (glitch && (out_glitches != 8'hFF))
      out_glitches <= out_glitches + 8'd1;
  end
`endif

endmodule

// File: doc/input_conditioner.md
# input_conditioner

- Front-end stage that turns an asynchronous, bouncy external input into a clean, debounced level and a one-cycle rising-edge pulse.
- Sits directly upstream of `pulse_extender`: `out_pulse` drives its `in_signal`.
- The debounce threshold is runtime-programmable through the same `in_set`/`in_value`/`out_ack` handshake that `pulse_extender` uses, so both blocks share one configuration path.

## Interface
- `SYNC_STAGES`, default 2: number of synchronizer flops on `in_raw`; legal values are 2 or more.
- `in_clock` input 1: sole clock; all flops are rising-edge.
- `in_reset` input 1: asynchronous reset, active-low.
- `in_set` input 1: write strobe for the debounce threshold.
- `in_value` input 8: threshold value, sampled when `in_set`=1.
- `out_ack` output 1: acknowledge for `in_set`.
- `in_raw` input 1: asynchronous external input.
- `out_level` output 1: debounced level.
- `out_pulse` output 1: one-cycle pulse on a debounced rising edge.
- `out_glitches` output 8: rejected-transition count; the port exists only when `INPUT_CONDITIONER_GLITCH_COUNT_EN` is defined.

## Operation
- Reset (`in_reset`=0, asynchronous):
  - All synchronizer flops, `out_level`, `out_pulse`, `out_ack`, the FSM counter and `out_glitches` go to 0.
  - The FSM goes to LOW and the threshold T goes to 4.
- Threshold write:
  - On an edge with `in_set`=1: T <= `in_value`, and `out_ack` <= 1.
  - Otherwise `out_ack` <= 0.
  - Holding `in_set` high keeps `out_ack` high.
  - `in_value`=0 is stored as 1.
  - A new T takes effect at the next edge's comparison. An in-progress count is not cleared.
- Synchronizer: `in_raw` passes through `SYNC_STAGES` flops. `s` is the last flop's output.
- Counter `cnt` is 8 bits.
- FSM states are LOW, QUAL_HIGH, HIGH, QUAL_LOW.
  - LOW, `s`=1:
    - If T=1, go to HIGH.
    - Otherwise go to QUAL_HIGH with `cnt`<=1.
  - LOW, `s`=0: stay in LOW.
  - QUAL_HIGH, `s`=0: go to LOW and count a glitch.
  - QUAL_HIGH, `s`=1:
    - If `cnt`+1 >= T, go to HIGH.
    - Otherwise `cnt`<=`cnt`+1.
    - The compare is done at 9 bits; `cnt` never wraps.
  - HIGH: mirror of LOW with polarity inverted (`s`=0 starts QUAL_LOW).
  - QUAL_LOW: mirror of QUAL_HIGH with polarity inverted (`s`=1 returns to HIGH and counts a glitch).
- `out_level` is 1 in HIGH and QUAL_LOW, and 0 in LOW and QUAL_HIGH.
- `out_pulse` is 1 for exactly the one cycle following the edge that enters HIGH from LOW or QUAL_HIGH.
- There is no pulse on falling edges and no pulse on a QUAL_LOW-to-HIGH return.
- If T is lowered below the current `cnt`, the next qualifying sample transitions immediately (because the compare is >=).

## Timing
- Number edges from 0, where edge 0 is the first edge that samples `in_raw`=1.
- `s` is high after edge `SYNC_STAGES`-1.
- `out_level` and `out_pulse` rise after edge `SYNC_STAGES`+T-1. For the defaults (`SYNC_STAGES`=2, T=4) that is edge 5.
- Falling latency is symmetric: `out_level` falls after edge `SYNC_STAGES`+T-1, counting from the first edge that samples `in_raw`=0.
- `out_ack` follows `in_set` with one cycle of latency.
- All outputs are registered; there are no combinational paths from input to output.
- `in_set` arriving in the same cycle as a qualification is legal. The comparison on that edge uses the old T.

## Configuration
- `INPUT_CONDITIONER_GLITCH_COUNT_EN` defined:
  - Adds the 8-bit `out_glitches` port.
  - The counter increments on every QUAL_HIGH-to-LOW and every QUAL_LOW-to-HIGH transition.
  - It saturates at 255 and is cleared only by reset.
- `INPUT_CONDITIONER_GLITCH_COUNT_EN` undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Reset default: reset, then drive `in_raw` 0 to 1 and hold → `out_level` and `out_pulse` rise after edge 5; `out_pulse` is high for exactly 1 cycle.
- Threshold write: `in_set`=1 with `in_value`=10 for 1 cycle → `out_ack`=1 for 1 cycle. A step on `in_raw` then gives a rise after edge 11. Repeating with `in_value`=0 behaves as T=1, giving a rise after edge 2.
- Glitch rejection (T=4): a 3-cycle high blip on `in_raw` → `out_level` stays 0, `out_pulse` never fires, and `out_glitches`=1 (macro on).
- Falling bounce (T=4): `out_level`=1, then a 2-cycle low blip → `out_level` stays 1, no pulse, and `out_glitches` increments. A sustained low drops `out_level` after edge 5.
- Mid-count threshold change: T=20 with `in_raw` high for 8 cycles, then write T=4 → transition to HIGH on the next edge that samples `s`=1.
- Asynchronous reset mid-QUAL_HIGH: assert `in_reset`=0 → all outputs are 0 immediately, without waiting for a clock edge, and T returns to 4. With 300 glitches injected (macro on), `out_glitches` reads 255.
